// File: rtl/pic10_pkg.sv
// Shared constants for the PIC10-class core: IR width, NOP encoding and ir_class codes.
// The classify helper is the single definition of the class map.
package pic10_pkg;

    localparam int unsigned IR_WIDTH = 12;
    localparam logic [11:0] IR_NOP   = 12'h000;

    localparam logic [2:0] CLS_CTRL  = 3'd0;
    localparam logic [2:0] CLS_BYTE  = 3'd1;
    localparam logic [2:0] CLS_BIT   = 3'd2;
    localparam logic [2:0] CLS_RETLW = 3'd3;
    localparam logic [2:0] CLS_CALL  = 3'd4;
    localparam logic [2:0] CLS_GOTO  = 3'd5;
    localparam logic [2:0] CLS_LIT   = 3'd6;

    function automatic logic [2:0] ir_classify(input logic [11:0] ir);
        logic [2:0] cls;
        cls = CLS_CTRL;
        unique case (ir[11:10])
            2'b00: cls = (ir[9:5] == 5'd0) ? CLS_CTRL : CLS_BYTE;
            2'b01: cls = CLS_BIT;
            2'b10: begin
                unique case (ir[9:8])
                    2'b00:   cls = CLS_RETLW;
                    2'b01:   cls = CLS_CALL;
                    default: cls = CLS_GOTO;
                endcase
            end
            default: cls = CLS_LIT;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pic10_ir_decode.sv
// Combinational decode of the held instruction word into class code and operand fields.
// Only instantiated when PIC10_IR_DECODE_EN is defined.
module pic10_ir_decode
    import pic10_pkg::*;
(
    input  logic [IR_WIDTH-1:0] ir,
    output logic [2:0]          ir_class,
    output logic [4:0]          ir_f_addr,
    output logic                ir_d,
    output logic [2:0]          ir_b,
    output logic [7:0]          ir_k8,
    output logic [8:0]          ir_k9
);

    always_comb begin
        ir_class  = ir_classify(ir);
        ir_f_addr = ir[4:0];
        ir_d      = ir[5];
        ir_b      = ir[7:5];
        ir_k8     = ir[7:0];
        ir_k9     = ir[8:0];
    end

endmodule

// File: rtl/pic10_ir.sv
// Instruction register for a PIC10-class core: capture, hold, flush-to-NOP.
// Define PIC10_IR_DECODE_EN to build the class/field decode; otherwise those outputs are 0.
module pic10_ir
    import pic10_pkg::*;
#(
    parameter logic [IR_WIDTH-1:0] RESET_WORD = IR_NOP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_ir_reg,
    input  logic                flush_ir,
    input  logic [IR_WIDTH-1:0] program_bus,
    output logic [IR_WIDTH-1:0] ir_reg_bus,
    output logic [2:0]          ir_class,
    output logic [4:0]          ir_f_addr,
    output logic                ir_d,
    output logic [2:0]          ir_b,
    output logic [7:0]          ir_k8,
    output logic [8:0]          ir_k9
);

    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] w_ir_next;

    // Flush outranks load so a taken branch always kills the fetched word.
    always_comb begin
        w_ir_next = r_ir;
        if (flush_ir) begin
            w_ir_next = RESET_WORD;
        end else if (load_ir_reg) begin
            w_ir_next = program_bus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir <= RESET_WORD;
        end else begin
            r_ir <= w_ir_next;
        end
    end

    assign ir_reg_bus = r_ir;

`ifdef PIC10_IR_DECODE_EN
    pic10_ir_decode u_decode (
        .ir        (r_ir),
        .ir_class  (ir_class),
        .ir_f_addr (ir_f_addr),
        .ir_d      (ir_d),
        .ir_b      (ir_b),
        .ir_k8     (ir_k8),
        .ir_k9     (ir_k9)
    );
`else
    assign ir_class  = 3'd0;
    assign ir_f_addr = 5'd0;
    assign ir_d      = 1'b0;
    assign ir_b      = 3'd0;
    assign ir_k8     = 8'd0;
    assign ir_k9     = 9'd0;
`endif

endmodule

// File: tb/tb_pic10_ir.sv
// Directed bench for pic10_ir: reset, load/hold, flush priority, async reset, decode fields.
// Decode checks follow PIC10_IR_DECODE_EN the same way the design does.
module tb_pic10_ir;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_ir_reg = 1'b0;
    logic        flush_ir = 1'b0;
    logic [11:0] program_bus = 12'h000;
    logic [11:0] ir_reg_bus;
    logic [2:0]  ir_class;
    logic [4:0]  ir_f_addr;
    logic        ir_d;
    logic [2:0]  ir_b;
    logic [7:0]  ir_k8;
    logic [8:0]  ir_k9;

    int n_checks = 0;
    int n_errors = 0;

    pic10_ir dut (
        .clk         (clk),
        .reset       (reset),
        .load_ir_reg (load_ir_reg),
        .flush_ir    (flush_ir),
        .program_bus (program_bus),
        .ir_reg_bus  (ir_reg_bus),
        .ir_class    (ir_class),
        .ir_f_addr   (ir_f_addr),
        .ir_d        (ir_d),
        .ir_b        (ir_b),
        .ir_k8       (ir_k8),
        .ir_k9       (ir_k9)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %03h, expected %03h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [11:0] w);
        program_bus = w;
        load_ir_reg = 1'b1;
        tick();
        load_ir_reg = 1'b0;
    endtask

    initial begin
        // 1: reset asserted at t=0, before any edge
        reset = 1'b0;
        #1;
        check("reset_before_edge", ir_reg_bus, 12'h000);
        load_ir_reg = 1'b1;
        program_bus = 12'hABC;
        tick();
        tick();
        check("reset_ignores_load", ir_reg_bus, 12'h000);
        flush_ir = 1'b1;
        tick();
        check("reset_ignores_flush", ir_reg_bus, 12'h000);
        flush_ir    = 1'b0;
        load_ir_reg = 1'b0;

        // 2: load and hold
        @(negedge clk);
        reset = 1'b1;
        load_word(12'hABC);
        check("load_abc", ir_reg_bus, 12'hABC);
        program_bus = 12'h555;
        tick();
        check("hold_abc", ir_reg_bus, 12'hABC);
        tick();
        check("hold_abc_2", ir_reg_bus, 12'hABC);
        load_word(12'h555);
        check("load_555", ir_reg_bus, 12'h555);

        // 3: flush wins over simultaneous load
        load_word(12'hABC);
        program_bus = 12'h123;
        load_ir_reg = 1'b1;
        flush_ir    = 1'b1;
        tick();
        load_ir_reg = 1'b0;
        flush_ir    = 1'b0;
        check("flush_priority", ir_reg_bus, 12'h000);
        load_word(12'h3C5);
        flush_ir = 1'b1;
        tick();
        flush_ir = 1'b0;
        check("flush_alone", ir_reg_bus, 12'h000);

        // 4: asynchronous reset between edges
        load_word(12'hABC);
        check("reload_abc", ir_reg_bus, 12'hABC);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", ir_reg_bus, 12'h000);
        reset = 1'b1;
        #1;
        check("async_release_holds", ir_reg_bus, 12'h000);

`ifdef PIC10_IR_DECODE_EN
        // 5: decode
        load_word(12'hA05);
        check("a05_class", {9'd0, ir_class}, 12'd5);
        check("a05_k9", {3'd0, ir_k9}, 12'h005);
        load_word(12'h5C3);
        check("5c3_class", {9'd0, ir_class}, 12'd2);
        check("5c3_b", {9'd0, ir_b}, 12'd6);
        check("5c3_f", {7'd0, ir_f_addr}, 12'h003);
        load_word(12'h0E7);
        check("0e7_class", {9'd0, ir_class}, 12'd1);
        check("0e7_d", {11'd0, ir_d}, 12'd1);
        check("0e7_f", {7'd0, ir_f_addr}, 12'h007);
        load_word(12'hC3F);
        check("c3f_class", {9'd0, ir_class}, 12'd6);
        check("c3f_k8", {4'd0, ir_k8}, 12'h03F);
        load_word(12'h000);
        check("000_class", {9'd0, ir_class}, 12'd0);
        load_word(12'h803);
        check("803_class", {9'd0, ir_class}, 12'd3);
        load_word(12'h9F0);
        check("9f0_class", {9'd0, ir_class}, 12'd4);
        load_word(12'h01F);
        check("01f_class", {9'd0, ir_class}, 12'd0);
        load_word(12'h020);
        check("020_class", {9'd0, ir_class}, 12'd1);
`else
        // 6: decode disabled, outputs tied off
        load_word(12'hA05);
        check("nodec_ir", ir_reg_bus, 12'hA05);
        check("nodec_class", {9'd0, ir_class}, 12'd0);
        check("nodec_f", {7'd0, ir_f_addr}, 12'd0);
        check("nodec_d", {11'd0, ir_d}, 12'd0);
        check("nodec_b", {9'd0, ir_b}, 12'd0);
        check("nodec_k8", {4'd0, ir_k8}, 12'd0);
        check("nodec_k9", {3'd0, ir_k9}, 12'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
